// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the data-memory controller.
//   - dm_size_e  : request access size
//   - dm_fault_e : response fault code
//   - dm_state_e : controller FSM states
//   - dm_misaligned(): alignment rule shared by the controller
package dm_pkg;

    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2,
        SizeRsvd = 2'd3
    } dm_size_e;

    typedef enum logic [1:0] {
        FaultNone     = 2'd0,
        FaultMisalign = 2'd1,
        FaultRange    = 2'd2,
        FaultAbort    = 2'd3
    } dm_fault_e;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StClear = 1'b1
    } dm_state_e;

    // off_w is log2 of the word size in bytes; a full-word access must have
    // all of those low address bits clear.
    function automatic logic dm_misaligned(input logic [1:0]  size,
                                           input logic [31:0] addr,
                                           input int unsigned off_w);
        logic [31:0] mask;
        mask = (32'd1 << off_w) - 32'd1;
        case (size)
            SizeByte: return 1'b0;
            SizeHalf: return addr[0];
            SizeWord: return (addr & mask) != 32'd0;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_ctrl_if.sv
// dm_ctrl_if: request/response bus of the data-memory controller.
//   Request : req_valid/req_ready, req_we, req_size, req_signed, req_addr,
//             req_wdata, req_pc, abort
//   Response: rsp_valid/rsp_ready, rsp_rdata, rsp_fault, rsp_pc
//   Control : clear_req (start zero-fill), busy (zero-fill running)
// master = requester side, slave = controller side.
interface dm_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [31:0]       req_pc;
    logic              abort;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_fault;
    logic [31:0]       rsp_pc;
    logic              clear_req;
    logic              busy;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_pc, abort,
        output rsp_ready, clear_req,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_pc, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_pc, abort,
        input  rsp_ready, clear_req,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_pc, busy
    );

endinterface

// File: rtl/dm_ram.sv
// dm_ram: single-port storage array with byte-lane write enables and a
// registered (synchronous) read. Contents are not reset.
//   clk     : clock
//   i_addr  : word index
//   i_we    : write strobe, i_be selects byte lanes, i_wdata lane-aligned data
//   i_re    : read strobe; o_rdata updates only on a read and holds otherwise
module dm_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2048
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic                     i_we,
    input  logic [DATA_W/8-1:0]      i_be,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_re,
    output logic [DATA_W-1:0]        o_rdata
);
    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < NB; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_ctrl.sv
// dm_ctrl: data-memory controller. Accepts byte/half/word loads and stores
// on a valid/ready request channel, checks alignment/range/abort, accesses
// dm_ram and returns one response per transfer with latency 1. A clear_req
// in idle zero-fills the whole array one word per cycle while busy is high.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : dm_ctrl_if slave (request, response, clear_req/busy)
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 2048,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     reset,
    dm_ctrl_if.slave bus
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    // FSM
    dm_state_e          r_state;
    dm_state_e          w_state_next;
    logic [IDX_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   w_cnt_next;

    // request decode
    logic               w_busy;
    logic               w_req_ready;
    logic               w_xfer;
    logic [OFF_W-1:0]   w_off;
    logic [31:0]        w_rel;
    logic [31:0]        w_index;
    logic               w_misalign;
    logic               w_range;
    dm_fault_e          w_fault;
    logic [NB-1:0]      w_be;
    logic [DATA_W-1:0]  w_wdata_sh;

    // RAM port
    logic [IDX_W-1:0]   w_ram_addr;
    logic               w_ram_we;
    logic               w_ram_re;
    logic [NB-1:0]      w_ram_be;
    logic [DATA_W-1:0]  w_ram_wdata;
    logic [DATA_W-1:0]  w_ram_rdata;

    // response register
    logic               r_rsp_valid;
    dm_fault_e          r_rsp_fault;
    logic [31:0]        r_rsp_pc;
    logic               r_rsp_load;
    logic               r_rsp_signed;
    dm_size_e           r_rsp_size;
    logic [OFF_W-1:0]   r_rsp_off;
    logic [DATA_W-1:0]  w_lane_data;
    logic [DATA_W-1:0]  w_rsp_rdata;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_busy      = (r_state == StClear);
    // A new request may only enter when the single response slot is free
    // or is being drained in the same cycle.
    assign w_req_ready = !w_busy && (!r_rsp_valid || bus.rsp_ready);
    assign w_xfer      = bus.req_valid && w_req_ready;

    assign w_off      = bus.req_addr[OFF_W-1:0];
    assign w_rel      = bus.req_addr - BASE_ADDR;
    assign w_index    = w_rel >> OFF_W;
    assign w_misalign = dm_misaligned(bus.req_size, bus.req_addr, OFF_W);
    assign w_range    = (bus.req_addr < BASE_ADDR) || (w_index >= DEPTH);

    always_comb begin
        w_fault = FaultNone;
        if (w_misalign) begin
            w_fault = FaultMisalign;
        end else if (w_range) begin
            w_fault = FaultRange;
        end else if (bus.req_we && bus.abort) begin
            w_fault = FaultAbort;
        end
    end

    always_comb begin
        w_be = '0;
        case (bus.req_size)
            SizeByte: w_be = {{(NB-1){1'b0}}, 1'b1} << w_off;
            SizeHalf: w_be = {{(NB-2){1'b0}}, 2'b11} << w_off;
            default:  w_be = '1;
        endcase
    end

    assign w_wdata_sh = bus.req_wdata << {w_off, 3'b000};

    // ------------------------------------------------------------------
    // RAM port: the zero-fill owns the port while busy, otherwise only
    // fault-free transfers touch the array.
    // ------------------------------------------------------------------
    always_comb begin
        w_ram_addr  = w_index[IDX_W-1:0];
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_be    = w_be;
        w_ram_wdata = w_wdata_sh;
        if (w_busy) begin
            w_ram_addr  = r_cnt;
            w_ram_we    = 1'b1;
            w_ram_be    = '1;
            w_ram_wdata = '0;
        end else if (w_xfer && (w_fault == FaultNone)) begin
            w_ram_we = bus.req_we;
            w_ram_re = !bus.req_we;
        end
    end

    dm_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .o_rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Zero-fill FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle: begin
                // Only start when the bus is free and no request competes.
                if (bus.clear_req && w_req_ready && !bus.req_valid) begin
                    w_state_next = StClear;
                    w_cnt_next   = '0;
                end
            end
            StClear: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == IDX_W'(DEPTH - 1)) begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Response slot. Formatting metadata is captured with the transfer;
    // the RAM output only moves on a read, so the formatted data stays
    // stable while the response is stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_fault  <= FaultNone;
            r_rsp_pc     <= '0;
            r_rsp_load   <= 1'b0;
            r_rsp_signed <= 1'b0;
            r_rsp_size   <= SizeByte;
            r_rsp_off    <= '0;
        end else if (w_xfer) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_fault  <= w_fault;
            r_rsp_pc     <= bus.req_pc;
            r_rsp_load   <= !bus.req_we && (w_fault == FaultNone);
            r_rsp_signed <= bus.req_signed;
            r_rsp_size   <= dm_size_e'(bus.req_size);
            r_rsp_off    <= w_off;
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign w_lane_data = w_ram_rdata >> {r_rsp_off, 3'b000};

    always_comb begin
        w_rsp_rdata = '0;
        if (r_rsp_load) begin
            case (r_rsp_size)
                SizeByte: w_rsp_rdata = {{(DATA_W-8){r_rsp_signed & w_lane_data[7]}},
                                         w_lane_data[7:0]};
                SizeHalf: w_rsp_rdata = {{(DATA_W-16){r_rsp_signed & w_lane_data[15]}},
                                         w_lane_data[15:0]};
                default:  w_rsp_rdata = w_lane_data;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = w_rsp_rdata;
    assign bus.rsp_fault = r_rsp_fault;
    assign bus.rsp_pc    = r_rsp_pc;
    assign bus.busy      = w_busy;

endmodule

// File: doc/dm_ctrl.md
DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory word width in bits (multiple of 8, at least 32).
REQ-002 SHALL have parameter DEPTH, default 2048, word count (power of two).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1: request handshake; a transfer occurs when both are high at a rising edge.
REQ-007 SHALL have port req_we  in  1  1=store, 0=load.
REQ-008 SHALL have port req_size  in  2  0=byte, 1=half, 2=full word; 3 is reserved.
REQ-009 SHALL have port req_signed  in  1  sign-extend sub-word loads when high.
REQ-010 SHALL have ports req_addr in 32 (byte address), req_wdata in DATA_W (store data, right-aligned), req_pc in 32 (tag for fault reporting).
REQ-011 SHALL have port abort  in  1  kills the write of the request transferring in the same cycle.
REQ-012 SHALL have ports rsp_valid out 1, rsp_ready in 1: response handshake.
REQ-013 SHALL have ports rsp_rdata out DATA_W (aligned, extended load data), rsp_fault out 2 (fault code), rsp_pc out 32 (req_pc of the request).
REQ-014 SHALL have ports clear_req in 1 (start zero-fill) and busy out 1 (zero-fill in progress).

Function
REQ-015 SHALL compute lane offset = req_addr[log2(DATA_W/8)-1:0] and index = (req_addr-BASE_ADDR)>>log2(DATA_W/8).
REQ-016 SHALL derive the byte-lane enables internally: byte -> 1 lane at offset, half -> 2 lanes, full -> all lanes; store data is shifted to lane offset*8.
REQ-017 SHALL flag fault 1 (misaligned) for: half at odd address; full not word-aligned; size 3.
REQ-018 SHALL flag fault 2 (range) when index >= DEPTH or req_addr < BASE_ADDR; misaligned takes priority.
REQ-019 SHALL flag fault 3 (aborted) on a store transferred with abort high and no other fault.
REQ-020 SHALL write memory at the transfer edge only for a store with fault 0; faulted or aborted stores leave memory unchanged.
REQ-021 SHALL read synchronously: load data is registered at the transfer edge, and rsp_valid is high the following cycle (latency 1).
REQ-022 SHALL return loads shifted down by offset*8, zero- or sign-extended per req_signed; stores and faulted requests return rsp_rdata=0.
REQ-023 SHALL produce exactly one response per transfer, in order.
REQ-024 SHALL hold rsp_valid/rsp_rdata/rsp_fault/rsp_pc stable while rsp_valid && !rsp_ready; req_ready = !busy && (!rsp_valid || rsp_ready).
REQ-025 SHALL return post-write data to a load transferred in the cycle after a store to the same word.
REQ-026 SHALL implement FSM IDLE/CLEAR: IDLE->CLEAR on clear_req while req_ready and no request transfers that cycle; CLEAR writes 0 to index cnt, cnt increments each cycle; CLEAR->IDLE after cnt=DEPTH-1.
REQ-027 SHALL hold busy=1 and req_ready=0 throughout CLEAR; clear_req in CLEAR is ignored; clear_req coincident with a transfer is ignored.

Reset
REQ-028 SHALL on reset=0 force IDLE, cnt=0, busy=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0, rsp_pc=0; req_ready=1 after release.
REQ-029 SHALL NOT reset memory contents; reset during CLEAR aborts it, leaving the array partially zeroed.
REQ-030 SHALL discard any pending response on reset.

Structure
REQ-031 SHALL place fault-code constants, size encodings and FSM state encodings in shared package dm_pkg.
REQ-032 SHALL isolate the storage array in sub-module dm_ram (byte-lane write enable, synchronous read, DATA_W/DEPTH parameters).

Verification
REQ-033 SHALL test: store full 32'hDEADBEEF @0x10, then load byte signed @0x13 -> rsp_rdata=32'hFFFFFFDE, fault 0, one cycle after transfer.
REQ-034 SHALL test: store half 16'h8001 @0x22, then load half unsigned @0x22 -> 32'h00008001; load full @0x20 -> 32'h8001_xxxx with the low half unchanged.
REQ-035 SHALL test: load half @0x3, store full @0x2000 (DEPTH=2048) -> faults 1 and 2; the store leaves memory unchanged.
REQ-036 SHALL test: store with abort=1 -> fault 3, memory unchanged; rsp_ready=0 for 3 cycles -> response stable, req_ready=0.
REQ-037 SHALL test: clear_req in IDLE -> busy high for exactly DEPTH cycles, then every word reads 0; reset mid-clear -> busy=0 immediately.
